// File: rtl/max7219_rx_pkg.sv
// Shared definitions for the MAX7219 bus snooper: register addresses, the
// per-device register file and its write/read helpers.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

    typedef struct packed {
        logic [7:0][7:0] digit;
        logic [7:0]      decode;
        logic [3:0]      intensity;
        logic [2:0]      scan_limit;
        logic            shutdown;
        logic            disp_test;
    } dev_regs_t;

    localparam dev_regs_t DEV_REGS_RST = '0;

    // Narrow registers keep only their implemented low bits.
    function automatic dev_regs_t dev_write(input dev_regs_t regs, input logic [3:0] addr,
                                            input logic [7:0] data);
        dev_regs_t r;
        r = regs;
        case (addr)
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                r.digit[3'(addr - 4'd1)] = data;
            ADDR_DECODE:    r.decode     = data;
            ADDR_INTENSITY: r.intensity  = data[3:0];
            ADDR_SCANLIMIT: r.scan_limit = data[2:0];
            ADDR_SHUTDOWN:  r.shutdown   = data[0];
            ADDR_DISPTEST:  r.disp_test  = data[0];
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] dev_read(input dev_regs_t regs, input logic [3:0] addr);
        logic [7:0] v;
        v = 8'h00;
        case (addr)
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                v = regs.digit[3'(addr - 4'd1)];
            ADDR_DECODE:    v = regs.decode;
            ADDR_INTENSITY: v = {4'h0, regs.intensity};
            ADDR_SCANLIMIT: v = {5'h00, regs.scan_limit};
            ADDR_SHUTDOWN:  v = {7'h00, regs.shutdown};
            ADDR_DISPTEST:  v = {7'h00, regs.disp_test};
            default:        v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/max7219_rx_if.sv
// Bundle of the snooped MAX7219 pins, the register read port and frame status.
interface max7219_rx_if #(
    parameter int unsigned NUM_DEVICES = 4
);
    logic                   max_cs;
    logic                   max_clk;
    logic                   max_din;
    logic [2:0]             rd_dev;
    logic [3:0]             rd_addr;
    logic [7:0]             rd_data;
    logic                   frame_valid;
    logic                   frame_err;
    logic [NUM_DEVICES-1:0] shutdown_n;

    modport master (
        output max_cs, max_clk, max_din, rd_dev, rd_addr,
        input  rd_data, frame_valid, frame_err, shutdown_n
    );

    modport slave (
        input  max_cs, max_clk, max_din, rd_dev, rd_addr,
        output rd_data, frame_valid, frame_err, shutdown_n
    );
endinterface

// File: rtl/max7219_rx_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin with rise/fall pulses
// derived from the synchronized level and a one-flop history.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        HIST_RST    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= HIST_RST;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_hist;
    assign o_fall = ~o_sync & r_hist;
endmodule

// File: rtl/max7219_rx.sv
// Snoops a MAX7219 daisy chain and mirrors every device's registers.
// Optional MAX7219_RX_VISIBLE_EN: digit reads return the pixels actually lit.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int unsigned NUM_DEVICES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    max7219_rx_if.slave  bus
);
    localparam int unsigned FRAME_BITS = 16 * NUM_DEVICES;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_clk_sync, w_clk_rise, w_clk_fall;
    logic w_din_sync, w_din_rise, w_din_fall;
    logic w_unused_ok;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .HIST_RST(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.max_cs),
        .o_sync (w_cs_sync),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .HIST_RST(1'b0)) u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.max_clk),
        .o_sync (w_clk_sync),
        .o_rise (w_clk_rise),
        .o_fall (w_clk_fall)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .HIST_RST(1'b0)) u_din_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.max_din),
        .o_sync (w_din_sync),
        .o_rise (w_din_rise),
        .o_fall (w_din_fall)
    );

    assign w_unused_ok = ^{w_clk_sync, w_clk_fall, w_din_rise, w_din_fall};

    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_pend_valid, r_pend_err;
    logic                  r_frame_valid, r_frame_err;
    logic [7:0]            r_rd_data;
    dev_regs_t             r_regs [NUM_DEVICES];

    logic w_shift_en;
    logic w_latch;
    assign w_shift_en = w_clk_rise & ~w_cs_sync;
    assign w_latch    = w_cs_rise && (r_bit_cnt >= CNT_W'(16));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_err    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            for (int d = 0; d < NUM_DEVICES; d++) begin
                r_regs[d] <= DEV_REGS_RST;
            end
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_din_sync};
            end

            if (w_cs_fall) begin
                r_bit_cnt <= w_shift_en ? CNT_W'(1) : '0;
            end else if (w_shift_en && (r_bit_cnt != CNT_W'(FRAME_BITS))) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            // Status is staged one cycle so frame_valid follows the latch.
            r_pend_valid  <= w_latch;
            r_pend_err    <= w_cs_rise && (r_bit_cnt != CNT_W'(FRAME_BITS));
            r_frame_valid <= r_pend_valid;
            r_frame_err   <= r_pend_err;

            if (w_latch) begin
                for (int d = 0; d < NUM_DEVICES; d++) begin
                    r_regs[d] <= dev_write(r_regs[d], r_shift[16*d+8 +: 4], r_shift[16*d +: 8]);
                end
            end
        end
    end

    dev_regs_t  w_sel_regs;
    logic       w_sel_hit;
    logic [7:0] w_rd_val;

    always_comb begin
        w_sel_regs = DEV_REGS_RST;
        w_sel_hit  = 1'b0;
        for (int d = 0; d < NUM_DEVICES; d++) begin
            if (bus.rd_dev == 3'(d)) begin
                w_sel_regs = r_regs[d];
                w_sel_hit  = 1'b1;
            end
        end
        w_rd_val = w_sel_hit ? dev_read(w_sel_regs, bus.rd_addr) : 8'h00;
`ifdef MAX7219_RX_VISIBLE_EN
        if (w_sel_hit && (bus.rd_addr >= ADDR_DIGIT0) && (bus.rd_addr <= ADDR_DIGIT7)) begin
            if (w_sel_regs.disp_test) begin
                w_rd_val = 8'hFF;
            end else if (!w_sel_regs.shutdown ||
                         (3'(bus.rd_addr - 4'd1) > w_sel_regs.scan_limit)) begin
                w_rd_val = 8'h00;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= w_rd_val;
        end
    end

    logic [NUM_DEVICES-1:0] w_shutdown_n;
    always_comb begin
        w_shutdown_n = '0;
        for (int d = 0; d < NUM_DEVICES; d++) begin
            w_shutdown_n[d] = r_regs[d].shutdown;
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.shutdown_n  = w_shutdown_n;
endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: frames are driven on the pins, expected frame
// status is queued per frame and matched by a monitor, register reads checked.
module tb_max7219_rx;
    localparam int unsigned NDEV = 4;
`ifdef MAX7219_RX_VISIBLE_EN
    localparam bit VIS = 1'b1;
`else
    localparam bit VIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] exp_q[$];  // {frame_valid, frame_err}

    always #5 clk = ~clk;

    max7219_rx_if #(.NUM_DEVICES(NDEV)) bus ();

    max7219_rx #(.NUM_DEVICES(NDEV), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Every status pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.frame_valid || bus.frame_err)) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL frame_unexpected observed=%b%b required=none",
                       bus.frame_valid, bus.frame_err);
            end
            if (exp_q.size() != 0) begin
                logic [1:0] e;
                e = exp_q.pop_front();
                assert ({bus.frame_valid, bus.frame_err} === e) else begin
                    n_fail++;
                    $error("FAIL frame_status observed=%b%b required=%b",
                           bus.frame_valid, bus.frame_err, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] dev, input logic [3:0] addr,
                          input logic [7:0] exp);
        @(negedge clk);
        bus.rd_dev  = dev;
        bus.rd_addr = addr;
        @(posedge clk);
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [127:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.max_din = bits[n-1-i];
            wait_n(4);
            bus.max_clk = 1'b1;
            wait_n(4);
            bus.max_clk = 1'b0;
        end
        wait_n(4);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        wait_n(2);
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_timeout observed=pending%0d required=pending0", tag, exp_q.size());
        end
    endtask

    task automatic send_frame(input string tag, input logic [127:0] bits, input int n,
                              input logic [1:0] ev);
        @(negedge clk);
        bus.max_cs = 1'b0;
        wait_n(4);
        send_bits(bits, n);
        exp_q.push_back(ev);
        bus.max_cs = 1'b1;
        drain(tag);
    endtask

    initial begin
        int lat;
        bus.max_cs  = 1'b0;
        bus.max_clk = 1'b0;
        bus.max_din = 1'b0;
        bus.rd_dev  = 3'd0;
        bus.rd_addr = 4'd0;
        wait_n(3);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_status", {6'd0, bus.frame_valid, bus.frame_err}, 8'h00);
        chk("rst_shutdown_n", {4'd0, bus.shutdown_n}, 8'h00);
        rst_n = 1'b1;
        wait_n(5);

        // cs rise with no counted bits since reset: error only.
        exp_q.push_back(2'b01);
        bus.max_cs = 1'b1;
        drain("idle_rise");

        // Full frame; first word ends in the far device. Measure cs-rise latency.
        @(negedge clk);
        bus.max_cs = 1'b0;
        wait_n(4);
        send_bits({64'h0155_0203_0C01_0800}, 64);
        exp_q.push_back(2'b10);
        bus.max_cs = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency", 8'(lat), 8'd4);
        drain("full_frame");
        rd_chk("f1_dev3_d0", 3'd3, 4'h1, VIS ? 8'h00 : 8'h55);
        rd_chk("f1_dev2_d1", 3'd2, 4'h2, VIS ? 8'h00 : 8'h03);
        rd_chk("f1_dev1_shdn", 3'd1, 4'hC, 8'h01);
        rd_chk("f1_dev0_d7", 3'd0, 4'h8, 8'h00);
        chk("f1_shutdown_n", {4'd0, bus.shutdown_n}, 8'h02);

        // Short frame: devices 2-3 receive the previous frame's low words.
        send_frame("short_frame", {32'h0AFF_0F01}, 32, 2'b11);
        rd_chk("f2_dev1_int", 3'd1, 4'hA, 8'h0F);
        rd_chk("f2_dev0_test", 3'd0, 4'hF, 8'h01);
        rd_chk("f2_dev3_shdn", 3'd3, 4'hC, 8'h01);
        rd_chk("f2_dev1_shdn", 3'd1, 4'hC, 8'h01);
        chk("f2_shutdown_n", {4'd0, bus.shutdown_n}, 8'h0A);

        // Under 16 bits: nothing latched.
        send_frame("runt_frame", {8'hA5}, 8, 2'b01);
        rd_chk("f3_dev1_int", 3'd1, 4'hA, 8'h0F);
        rd_chk("f3_dev0_test", 3'd0, 4'hF, 8'h01);
        chk("f3_shutdown_n", {4'd0, bus.shutdown_n}, 8'h0A);

        // Reset in mid-frame.
        @(negedge clk);
        bus.max_cs = 1'b0;
        wait_n(4);
        send_bits({20'hFFFFF}, 20);
        rst_n = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(6);
        exp_q.push_back(2'b01);
        bus.max_cs = 1'b1;
        drain("reset_mid");
        rd_chk("f4_dev1_int", 3'd1, 4'hA, 8'h00);
        rd_chk("f4_dev0_test", 3'd0, 4'hF, 8'h00);
        chk("f4_shutdown_n", {4'd0, bus.shutdown_n}, 8'h00);

        // Bus clock toggled with cs high must not shift ones in.
        bus.max_din = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_n(4);
            bus.max_clk = 1'b1;
            wait_n(4);
            bus.max_clk = 1'b0;
        end
        wait_n(4);
        send_frame("after_idle_clk", {32'h0B07_0103}, 32, 2'b11);
        rd_chk("f5_dev2_test", 3'd2, 4'hF, 8'h00);
        rd_chk("f5_dev3_test", 3'd3, 4'hF, 8'h00);
        rd_chk("f5_dev1_scan", 3'd1, 4'hB, 8'h07);
        rd_chk("f5_dev0_d0", 3'd0, 4'h1, VIS ? 8'h00 : 8'h03);

        send_frame("full_frame2", {64'h0C01_0A05_0B02_0C01}, 64, 2'b10);
        rd_chk("f6_dev2_int", 3'd2, 4'hA, 8'h05);
        rd_chk("f6_dev1_scan", 3'd1, 4'hB, 8'h02);
        rd_chk("f6_dev0_d0", 3'd0, 4'h1, 8'h03);
        rd_chk("f6_bad_dev", 3'd5, 4'hA, 8'h00);
        rd_chk("f6_addr_d", 3'd0, 4'hD, 8'h00);
        rd_chk("f6_addr_0", 3'd2, 4'h0, 8'h00);
        chk("f6_shutdown_n", {4'd0, bus.shutdown_n}, 8'h09);

        // Visibility sequence on device 0 (raw value when feature is off).
        send_frame("vis_d3", {48'h0, 16'h043C}, 64, 2'b10);
        send_frame("vis_scan2", {48'h0, 16'h0B02}, 64, 2'b10);
        send_frame("vis_shdn1", {48'h0, 16'h0C01}, 64, 2'b10);
        rd_chk("vis_beyond_scan", 3'd0, 4'h4, VIS ? 8'h00 : 8'h3C);
        send_frame("vis_scan7", {48'h0, 16'h0B07}, 64, 2'b10);
        rd_chk("vis_in_scan", 3'd0, 4'h4, 8'h3C);
        send_frame("vis_test1", {48'h0, 16'h0F01}, 64, 2'b10);
        rd_chk("vis_test_on", 3'd0, 4'h4, VIS ? 8'hFF : 8'h3C);
        rd_chk("vis_test_reg", 3'd0, 4'hF, 8'h01);
        send_frame("vis_test0", {48'h0, 16'h0F00}, 64, 2'b10);
        send_frame("vis_shdn0", {48'h0, 16'h0C00}, 64, 2'b10);
        rd_chk("vis_shutdown", 3'd0, 4'h4, VIS ? 8'h00 : 8'h3C);
        rd_chk("vis_scan_reg", 3'd0, 4'hB, 8'h07);

        wait_n(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
